ellipse_layer: RTL and testbench
================================

# ellipse_layer

Parametrised, pipelined successor to the single-cycle ellipse shape stage in the render chain. Each instance owns one axis-aligned ellipse (filled or outlined), receives its geometry through the same program beats that flow down the chain, and overwrites `data_out` with its colour for pixels inside the shape. Parameters are double-buffered and applied atomically on a commit write. Pixel/program traffic passes through with a fixed latency of 3 cycles.

## Interface
- `SHAPE_ID`, 0: program address matched against `x` during program beats.
- `X_W`, 11: width of `x`, centre-x and x-radius.
- `Y_W`, 12: width of `y`, centre-y and y-radius.
- `DATA_W`, 32: pixel colour and program data width.
- `clk`  in  1  single clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `program_in`  in  1  1 = program beat, 0 = pixel beat.
- `x`  in  X_W  pixel x, or shape address on program beats.
- `y`  in  Y_W  pixel y, or register ID on program beats.
- `data_in`  in  DATA_W  upstream colour, or write data on program beats.
- `program_out`  out  1  `program_in` delayed 3 cycles.
- `x_out`  out  X_W  `x` delayed 3 cycles.
- `y_out`  out  Y_W  `y` delayed 3 cycles.
- `data_out`  out  DATA_W  own colour or `data_in` delayed 3 cycles.

## Operation
- Write: `program_in`=1 and `x`==SHAPE_ID writes the low bits of `data_in` to the shadow register selected by `y`. IDs: 0 cx (X_W), 1 cy (Y_W), 2 rx (X_W), 3 ry (Y_W), 4 colour (DATA_W), 5 thickness T (min(X_W,Y_W)), 6 mode (bit0 enable, bit1 outline), 7 commit (data ignored). Other IDs are ignored.
- Commit copies all shadow registers to the active set at the same edge. A write and a commit cannot land in the same beat, since only one ID exists per beat.
- Reset values, shadow and active: cx=cy=rx=ry=0, colour all-ones, T=0, mode=0b01 (enabled, fill).
- Inside test: dx=|x−cx|, dy=|y−cy| (unsigned, equal gives 0). Inside(rx,ry) ⇔ (dx·ry)² + (dy·rx)² < (rx·ry)².
  - All arithmetic is unsigned at full width: products X_W+Y_W bits, squares 2(X_W+Y_W), sum 2(X_W+Y_W)+1.
  - Strict `<`: rx=0 or ry=0 gives no pixels.
- Fill mode: hit = Inside(rx,ry).
- Outline mode: hit = Inside(rx,ry) and not Inside(rx−T, ry−T).
  - If T≥rx or T≥ry, the inner ellipse is empty and the result equals fill.
  - T=0 gives an empty outline.
- `data_out` = colour if the beat is a pixel beat, enable=1 and hit; otherwise `data_in` passes through unchanged.
- Program beats for any SHAPE_ID, including this instance's own, pass through unchanged.

## Timing
- Latency is exactly 3 cycles for all outputs; throughput is one beat per cycle with no stalls.
- Stage 1 registers dx, dy, the sideband and a snapshot of the active parameters. Stage 2 registers the products. Stage 3 compares, muxes and drives the outputs.
- A pixel sampled at edge t uses the active set valid at edge t. A commit at edge t affects pixels entering at t+1 and later; pixels already in flight keep their snapshot, so there is no tearing mid-pipeline.
- A shadow write at edge t is visible to a commit at t+1.
- Reset clears all pipeline registers, so all outputs are 0 at the first edge with `rst`=1. Outputs stay 0 for 3 cycles after `rst` falls, then follow inputs.
- Reset mid-operation drops in-flight beats and restores the default parameters in both sets.

## Structure
- Package `ellipse_pkg`:
  - register-ID constants REG_CX…REG_COMMIT
  - mode bit indices MODE_EN, MODE_OUTLINE
  - DEFAULT_COLOUR
  - LATENCY=3
- Sub-module `ellipse_inside_test`: a 2-stage pipelined inside test parameterised on X_W/Y_W, with inputs dx, dy, rx, ry and output a 1-bit hit. It is instantiated twice (outer and inner). The top level handles registers, commit, stage 1, the mode mux and sideband delay.

## Test plan
- Program cx=100, cy=50, rx=20, ry=10, colour=0xFF00FF00, then commit. Pixel (110,50) with data_in=0x0 → data_out=0xFF00FF00 3 cycles later; (120,50) → 0x0 (boundary excluded); (100,61) → 0x0.
- Same shape, write rx=40 without commit: pixel (130,50) → data_in unchanged. After commit, the next pixel (130,50) → colour. A pixel issued the cycle before the commit → data_in.
- Outline: mode=0b11, T=5, commit. Pixel (100,50) → data_in; (118,50) → colour. T=25 → (100,50) gives colour (fill fallback).
- Program beats: x=SHAPE_ID+1 and x=SHAPE_ID, y=4 each emerge unchanged after 3 cycles with program_out=1. The own-ID beat changes only the shadow register.
- Assert rst during a stream of hit pixels: outputs 0 from the next edge. After release, the first 3 outputs are 0, then the pixel (0,0) with data_in=0x12 → 0x12 (default rx=0 gives no hit).
- rx=ry=0 with enable=1: sweep 16 pixels around the centre → every data_out equals data_in.

Source files
------------

// File: rtl/ellipse_pkg.sv
// ellipse_pkg: shared constants for the ellipse shape layer.
//   - reg_id_e     : program register IDs carried on `y` during program beats
//   - MODE_EN/MODE_OUTLINE : bit positions inside the mode register
//   - DEFAULT_MODE / DEFAULT_COLOUR : reset values for both parameter sets
//   - LATENCY      : fixed pass-through latency of the layer in cycles
package ellipse_pkg;

  typedef enum logic [2:0] {
    REG_CX     = 3'd0,
    REG_CY     = 3'd1,
    REG_RX     = 3'd2,
    REG_RY     = 3'd3,
    REG_COLOUR = 3'd4,
    REG_THICK  = 3'd5,
    REG_MODE   = 3'd6,
    REG_COMMIT = 3'd7
  } reg_id_e;

  localparam int MODE_EN      = 0;
  localparam int MODE_OUTLINE = 1;

  localparam logic [1:0] DEFAULT_MODE = 2'b01;  // enabled, fill

  // Wide enough for any DATA_W up to 64; truncated at the point of use.
  localparam logic [63:0] DEFAULT_COLOUR = '1;

  localparam int LATENCY = 3;

endpackage

// File: rtl/ellipse_inside_test.sv
// ellipse_inside_test: two-stage pipelined inside test for an axis-aligned
// ellipse centred on the origin.
//   hit (two cycles after dx/dy/rx/ry) = (dx*ry)^2 + (dy*rx)^2 < (rx*ry)^2
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   dx, dy        : absolute distance from the centre
//   rx, ry        : radii (a zero radius never hits because of the strict <)
//   hit           : registered result
module ellipse_inside_test #(
  parameter int X_W = 11,
  parameter int Y_W = 12
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [X_W-1:0] dx,
  input  logic [Y_W-1:0] dy,
  input  logic [X_W-1:0] rx,
  input  logic [Y_W-1:0] ry,
  output logic           hit
);

  localparam int P_W   = X_W + Y_W;
  localparam int S_W   = 2 * P_W;
  localparam int SUM_W = S_W + 1;

  logic [P_W-1:0]   pa_d, pb_d, pr_d;
  logic [P_W-1:0]   pa_q, pb_q, pr_q;
  logic [S_W-1:0]   sa_d, sb_d, sr_d;
  logic [SUM_W-1:0] lhs_d;
  logic             hit_d, hit_q;

  always_comb begin
    pa_d  = P_W'(dx) * P_W'(ry);
    pb_d  = P_W'(dy) * P_W'(rx);
    pr_d  = P_W'(rx) * P_W'(ry);
    sa_d  = S_W'(pa_q) * S_W'(pa_q);
    sb_d  = S_W'(pb_q) * S_W'(pb_q);
    sr_d  = S_W'(pr_q) * S_W'(pr_q);
    // One extra bit so the sum of two full-width squares cannot wrap.
    lhs_d = SUM_W'(sa_d) + SUM_W'(sb_d);
    hit_d = lhs_d < SUM_W'(sr_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pa_q  <= '0;
      pb_q  <= '0;
      pr_q  <= '0;
      hit_q <= 1'b0;
    end else begin
      pa_q  <= pa_d;
      pb_q  <= pb_d;
      pr_q  <= pr_d;
      hit_q <= hit_d;
    end
  end

  assign hit = hit_q;

endmodule

// File: rtl/ellipse_layer.sv
// ellipse_layer: one axis-aligned ellipse (filled or outlined) in the render
// chain. Program beats addressed to SHAPE_ID write shadow registers; a commit
// copies the shadow set to the active set. Pixels inside the shape get this
// layer's colour. Every beat emerges exactly 3 cycles later, no stalls.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   program_in          : 1 = program beat, 0 = pixel beat
//   x, y, data_in       : pixel coords/colour, or address/reg-ID/write-data
//   program_out, x_out, y_out, data_out : inputs delayed 3 cycles, with
//                         data_out replaced by the colour on a pixel hit
module ellipse_layer
  import ellipse_pkg::*;
#(
  parameter int SHAPE_ID = 0,
  parameter int X_W      = 11,
  parameter int Y_W      = 12,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              program_in,
  input  logic [X_W-1:0]    x,
  input  logic [Y_W-1:0]    y,
  input  logic [DATA_W-1:0] data_in,
  output logic              program_out,
  output logic [X_W-1:0]    x_out,
  output logic [Y_W-1:0]    y_out,
  output logic [DATA_W-1:0] data_out
);

  localparam int T_W  = (X_W < Y_W) ? X_W : Y_W;
  // Sideband carried through stages: {prog, x, y, data, colour, en, outline}
  localparam int SB_W = 1 + X_W + Y_W + DATA_W + DATA_W + 2;

  // Parameter registers: shadow (sh_) and active (act_)
  logic [X_W-1:0]    sh_cx_q, sh_rx_q, act_cx_q, act_rx_q;
  logic [Y_W-1:0]    sh_cy_q, sh_ry_q, act_cy_q, act_ry_q;
  logic [DATA_W-1:0] sh_colour_q, act_colour_q;
  logic [T_W-1:0]    sh_t_q, act_t_q;
  logic [1:0]        sh_mode_q, act_mode_q;

  logic    wr_en;
  reg_id_e reg_id;

  assign wr_en  = program_in && (x == X_W'(SHAPE_ID)) && (y[Y_W-1:3] == '0);
  assign reg_id = reg_id_e'(y[2:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_cx_q      <= '0;
      sh_cy_q      <= '0;
      sh_rx_q      <= '0;
      sh_ry_q      <= '0;
      sh_colour_q  <= DATA_W'(DEFAULT_COLOUR);
      sh_t_q       <= '0;
      sh_mode_q    <= DEFAULT_MODE;
      act_cx_q     <= '0;
      act_cy_q     <= '0;
      act_rx_q     <= '0;
      act_ry_q     <= '0;
      act_colour_q <= DATA_W'(DEFAULT_COLOUR);
      act_t_q      <= '0;
      act_mode_q   <= DEFAULT_MODE;
    end else if (wr_en) begin
      case (reg_id)
        REG_CX:     sh_cx_q     <= data_in[X_W-1:0];
        REG_CY:     sh_cy_q     <= data_in[Y_W-1:0];
        REG_RX:     sh_rx_q     <= data_in[X_W-1:0];
        REG_RY:     sh_ry_q     <= data_in[Y_W-1:0];
        REG_COLOUR: sh_colour_q <= data_in;
        REG_THICK:  sh_t_q      <= data_in[T_W-1:0];
        REG_MODE:   sh_mode_q   <= data_in[1:0];
        REG_COMMIT: begin
          act_cx_q     <= sh_cx_q;
          act_cy_q     <= sh_cy_q;
          act_rx_q     <= sh_rx_q;
          act_ry_q     <= sh_ry_q;
          act_colour_q <= sh_colour_q;
          act_t_q      <= sh_t_q;
          act_mode_q   <= sh_mode_q;
        end
      endcase
    end
  end

  // Stage 1: distances, inner radii and parameter snapshot
  logic [X_W-1:0]  dx_d, irx_d, t_x;
  logic [Y_W-1:0]  dy_d, iry_d, t_y;
  logic [SB_W-1:0] sb_d;

  always_comb begin
    t_x   = X_W'(act_t_q);
    t_y   = Y_W'(act_t_q);
    dx_d  = (x >= act_cx_q) ? (x - act_cx_q) : (act_cx_q - x);
    dy_d  = (y >= act_cy_q) ? (y - act_cy_q) : (act_cy_q - y);
    // A radius consumed by the thickness collapses to 0, which makes the inner
    // ellipse empty so the outline degenerates into a fill.
    irx_d = (t_x >= act_rx_q) ? '0 : (act_rx_q - t_x);
    iry_d = (t_y >= act_ry_q) ? '0 : (act_ry_q - t_y);
    sb_d  = {program_in, x, y, data_in, act_colour_q,
             act_mode_q[MODE_EN], act_mode_q[MODE_OUTLINE]};
  end

  logic [X_W-1:0]  s1_dx_q, s1_rx_q, s1_irx_q;
  logic [Y_W-1:0]  s1_dy_q, s1_ry_q, s1_iry_q;
  logic [SB_W-1:0] s1_sb_q, s2_sb_q, s3_sb_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_dx_q  <= '0;
      s1_dy_q  <= '0;
      s1_rx_q  <= '0;
      s1_ry_q  <= '0;
      s1_irx_q <= '0;
      s1_iry_q <= '0;
      s1_sb_q  <= '0;
      s2_sb_q  <= '0;
      s3_sb_q  <= '0;
    end else begin
      s1_dx_q  <= dx_d;
      s1_dy_q  <= dy_d;
      s1_rx_q  <= act_rx_q;
      s1_ry_q  <= act_ry_q;
      s1_irx_q <= irx_d;
      s1_iry_q <= iry_d;
      s1_sb_q  <= sb_d;
      s2_sb_q  <= s1_sb_q;
      s3_sb_q  <= s2_sb_q;
    end
  end

  // Stages 2 and 3: products, then compare
  logic outer_hit, inner_hit;

  ellipse_inside_test #(.X_W(X_W), .Y_W(Y_W)) u_outer (
    .clk (clk), .rst (rst),
    .dx  (s1_dx_q), .dy (s1_dy_q),
    .rx  (s1_rx_q), .ry (s1_ry_q),
    .hit (outer_hit)
  );

  ellipse_inside_test #(.X_W(X_W), .Y_W(Y_W)) u_inner (
    .clk (clk), .rst (rst),
    .dx  (s1_dx_q), .dy (s1_dy_q),
    .rx  (s1_irx_q), .ry (s1_iry_q),
    .hit (inner_hit)
  );

  // Stage 3 output mux
  logic              s3_prog, s3_en, s3_outline, hit;
  logic [DATA_W-1:0] s3_data, s3_colour;

  always_comb begin
    {s3_prog, x_out, y_out, s3_data, s3_colour, s3_en, s3_outline} = s3_sb_q;
    hit         = outer_hit && !(s3_outline && inner_hit);
    program_out = s3_prog;
    data_out    = (!s3_prog && s3_en && hit) ? s3_colour : s3_data;
  end

endmodule

// File: tb/tb_ellipse_layer.sv
// Directed bench for ellipse_layer. The driver pushes the expected output of
// every beat (with the cycle it is due) into a queue; an independent monitor
// pops and compares whenever an entry falls due.
module tb_ellipse_layer;
  import ellipse_pkg::*;

  localparam int X_W    = 11;
  localparam int Y_W    = 12;
  localparam int DATA_W = 32;
  localparam int SID    = 3;
  localparam int W      = 1 + X_W + Y_W + DATA_W;
  localparam logic [DATA_W-1:0] C  = 32'hFF00FF00;
  localparam logic [DATA_W-1:0] C2 = 32'h22222222;

  // Clock / reset
  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              program_in = 1'b0;
  logic [X_W-1:0]    x = '0;
  logic [Y_W-1:0]    y = '0;
  logic [DATA_W-1:0] data_in = '0;
  logic              program_out;
  logic [X_W-1:0]    x_out;
  logic [Y_W-1:0]    y_out;
  logic [DATA_W-1:0] data_out;

  always #5 clk = ~clk;

  ellipse_layer #(.SHAPE_ID(SID), .X_W(X_W), .Y_W(Y_W), .DATA_W(DATA_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .program_in  (program_in),
    .x           (x),
    .y           (y),
    .data_in     (data_in),
    .program_out (program_out),
    .x_out       (x_out),
    .y_out       (y_out),
    .data_out    (data_out)
  );

  // Scoreboard state
  logic [W-1:0] exp_q[$];
  int           due_q[$];
  int           cycle = 0;
  int           n_checks = 0;
  int           n_fail = 0;
  bit           was_rst = 1'b1;

  task automatic push(input int due, input logic [W-1:0] v);
    exp_q.push_back(v);
    due_q.push_back(due);
  endtask

  // Driver tasks
  task automatic beat(input logic p, input int bx, input int by,
                      input logic [DATA_W-1:0] bd, input logic [DATA_W-1:0] ed);
    @(negedge clk); #1;
    rst        = 1'b0;
    program_in = p;
    x          = X_W'(bx);
    y          = Y_W'(by);
    data_in    = bd;
    // Stages 2 and 3 still hold reset zeros for the next two cycles.
    if (was_rst) begin
      push(cycle + 1, '0);
      push(cycle + 2, '0);
    end
    was_rst = 1'b0;
    push(cycle + LATENCY, {p, X_W'(bx), Y_W'(by), ed});
  endtask

  task automatic prog(input reg_id_e id, input logic [DATA_W-1:0] d);
    beat(1'b1, SID, int'(id), d, d);
  endtask

  task automatic pix(input int px, input int py,
                     input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] e);
    beat(1'b0, px, py, d, e);
  endtask

  task automatic reset_cycles(input int n);
    repeat (n) begin
      @(negedge clk); #1;
      rst        = 1'b1;
      program_in = 1'b1;
      x          = X_W'(SID);
      y          = Y_W'(4);
      data_in    = 32'hDEADBEEF;
      // In-flight beats are dropped; outputs read 0 after the next edge.
      exp_q.delete();
      due_q.delete();
      push(cycle + 1, '0);
      was_rst = 1'b1;
    end
  endtask

  // Monitor
  initial begin
    logic [W-1:0] got, want;
    int           due;
    forever begin
      @(negedge clk);
      cycle++;
      while (due_q.size() > 0 && due_q[0] <= cycle) begin
        got  = {program_out, x_out, y_out, data_out};
        want = exp_q.pop_front();
        due  = due_q.pop_front();
        n_checks++;
        if (due != cycle || got !== want) begin
          n_fail++;
          $display("FAIL beat due %0d (cycle %0d): got prog=%0b x=%0d y=%0d data=%h, want prog=%0b x=%0d y=%0d data=%h",
                   due, cycle, got[W-1], got[W-2 -: X_W], got[DATA_W +: Y_W], got[DATA_W-1:0],
                   want[W-1], want[W-2 -: X_W], want[DATA_W +: Y_W], want[DATA_W-1:0]);
        end
      end
    end
  end

  // Stimulus
  initial begin
    reset_cycles(3);
    pix(0, 0, 32'h12, 32'h12);                 // defaults: rx=0, no hit

    prog(REG_CX, 32'd100);
    prog(REG_CY, 32'd50);
    prog(REG_RX, 32'd20);
    prog(REG_RY, 32'd10);
    prog(REG_COLOUR, C);
    pix(100, 50, 32'h21, 32'h21);              // shadow only, not yet active
    prog(REG_COMMIT, 32'h0);
    pix(110, 50, 32'h0,  C);
    pix(120, 50, 32'h0,  32'h0);               // boundary excluded
    pix(100, 61, 32'h0,  32'h0);
    pix(100, 60, 32'h31, 32'h31);              // boundary excluded in y
    pix(100, 59, 32'h32, C);
    pix(81,  50, 32'h33, C);                   // left of centre
    pix(80,  50, 32'h34, 32'h34);

    prog(REG_RX, 32'd40);
    pix(130, 50, 32'h5, 32'h5);                // still rx=20
    pix(130, 50, 32'h6, 32'h6);                // cycle before commit
    prog(REG_COMMIT, 32'h0);
    pix(130, 50, 32'h7, C);                    // rx=40 now active

    prog(REG_RX, 32'd20);
    prog(REG_MODE, 32'd3);
    prog(REG_THICK, 32'd5);
    prog(REG_COMMIT, 32'h0);
    pix(100, 50, 32'h41, 32'h41);              // inside inner ellipse
    pix(118, 50, 32'h42, C);
    pix(100, 58, 32'h43, C);
    pix(100, 54, 32'h44, 32'h44);
    pix(130, 50, 32'h45, 32'h45);              // outside outer

    prog(REG_THICK, 32'd25);
    prog(REG_COMMIT, 32'h0);
    pix(100, 50, 32'h51, C);                   // T>=rx: fill fallback
    pix(120, 50, 32'h52, 32'h52);

    prog(REG_THICK, 32'd0);
    prog(REG_COMMIT, 32'h0);
    pix(100, 50, 32'h61, 32'h61);              // T=0: empty outline
    pix(118, 50, 32'h62, 32'h62);

    prog(REG_MODE, 32'd1);
    beat(1'b1, SID + 1, 4, 32'h11111111, 32'h11111111);
    beat(1'b1, SID,     4, C2, C2);
    pix(110, 50, 32'h9, 32'h9);
    prog(REG_COMMIT, 32'h0);
    pix(110, 50, 32'h0, C2);

    prog(REG_MODE, 32'd0);
    prog(REG_COMMIT, 32'h0);
    pix(110, 50, 32'h71, 32'h71);              // disabled
    prog(REG_MODE, 32'd1);
    prog(REG_COMMIT, 32'h0);
    pix(110, 50, 32'h72, C2);

    pix(110, 50, 32'h1, C2);
    pix(110, 50, 32'h2, C2);                   // dropped by reset
    pix(110, 50, 32'h3, C2);                   // dropped by reset
    reset_cycles(2);
    pix(0,   0,  32'h12, 32'h12);
    pix(110, 50, 32'h13, 32'h13);              // defaults restored
    prog(REG_COMMIT, 32'h0);
    pix(110, 50, 32'h14, 32'h14);              // shadow was reset too

    prog(REG_CX, 32'd100);
    prog(REG_CY, 32'd50);
    prog(REG_RX, 32'd0);
    prog(REG_RY, 32'd0);
    prog(REG_MODE, 32'd1);
    prog(REG_COMMIT, 32'h0);
    for (int i = 0; i < 16; i++)
      pix(98 + (i % 4), 48 + (i / 4), 32'h100 + 32'(i), 32'h100 + 32'(i));

    // Bounded drain
    for (int i = 0; i < 20 && due_q.size() > 0; i++) @(negedge clk);
    n_checks++;
    if (due_q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending beats, want 0", due_q.size());
    end
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
